// File: rtl/audio_sample_feeder.sv
// Serial audio receiver, sample FIFO and fixed-rate sample release for the FM modulator.
// Optional build macro: UNDERFLOW_MUTE_EN (drive audio to 0 on an underflow tick).
module audio_sample_feeder #(
    parameter int A          = 8,
    parameter int DIV        = 1250,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  sdi,
    input  logic                  cs_n,
    input  logic                  clr_flags,
    output logic signed [A-1:0]   audio,
    output logic                  sample_stb,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  ovf,
    output logic                  unf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW    = (A > 1) ? $clog2(A) : 1;

    localparam logic [DW-1:0]         DIV_LAST   = DW'(DIV - 1);
    localparam logic [BW-1:0]         BIT_LAST   = BW'(A - 1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic               sclk_meta, sclk_sync, sclk_prev;
    logic               sdi_meta, sdi_sync;
    logic               cs_meta, cs_sync;
    logic               sclk_rise;

    logic [A-1:0]       shift_reg;
    logic [A-1:0]       shift_next;
    logic [BW-1:0]      bit_cnt;
    logic               push_req;
    logic [A-1:0]       push_word;

    logic [DW-1:0]      div_cnt;
    logic               tick;

    logic [A-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic               fifo_empty, fifo_full;
    logic               pop, wr_en;

    // cs_n synchroniser idles high so a reset never looks like an open frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            sdi_meta  <= 1'b0;
            sdi_sync  <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            sdi_meta  <= sdi;
            sdi_sync  <= sdi_meta;
            cs_meta   <= cs_n;
            cs_sync   <= cs_meta;
        end
    end

    assign sclk_rise  = sclk_sync & ~sclk_prev;
    assign shift_next = {shift_reg[A-2:0], sdi_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
        end else begin
            push_req <= 1'b0;
            if (cs_sync) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_reg <= shift_next;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt   <= '0;
                    push_req  <= 1'b1;
                    push_word <= shift_next;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // A full FIFO still accepts a word when a pop frees a slot in the same cycle
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LEVEL_FULL);
    assign pop        = tick & ~fifo_empty;
    assign wr_en      = push_req & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio      <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= pop;
            if (pop) begin
                audio <= mem[rd_ptr];
            end
`ifdef UNDERFLOW_MUTE_EN
            else if (tick) begin
                audio <= '0;
            end
`endif
        end
    end

    // Set conditions take priority over clr_flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push_req && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (tick && fifo_empty) begin
                unf <= 1'b1;
            end else if (clr_flags) begin
                unf <= 1'b0;
            end
        end
    end

    assign fifo_level = level;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Scoreboard bench for audio_sample_feeder: directed serial frames, expected samples queued at send time.
module tb_audio_sample_feeder;

    localparam int A          = 8;
    localparam int DIV        = 256;
    localparam int DEPTH_LOG2 = 2;

    logic                clk;
    logic                rst_n;
    logic                sclk;
    logic                sdi;
    logic                cs_n;
    logic                clr_flags;
    logic [A-1:0]        audio;
    logic                sample_stb;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                ovf;
    logic                unf;

    int                  checks;
    int                  errors;
    int                  ecount;
    logic [A-1:0]        exp_q [$];

    audio_sample_feeder #(
        .A          (A),
        .DIV        (DIV),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .sdi        (sdi),
        .cs_n       (cs_n),
        .clr_flags  (clr_flags),
        .audio      (audio),
        .sample_stb (sample_stb),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; a pop becomes visible exactly when this is a multiple of DIV
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    // Monitor: every strobe must pop the oldest expected sample
    always @(negedge clk) begin
        if (rst_n && sample_stb) begin
            logic [A-1:0] expv;
            checks++;
            if (ecount % DIV != 0) begin
                errors++;
                $display("[TB] FAIL stb_phase: strobe at edge %0d, required a multiple of %0d", ecount, DIV);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_stb: strobe at edge %0d with audio %h, required no strobe", ecount, audio);
            end else begin
                expv = exp_q.pop_front();
                if (audio !== expv) begin
                    errors++;
                    $display("[TB] FAIL sample: audio %h at edge %0d, required %h", audio, ecount, expv);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h at edge %0d, required %0h", name, actual, ecount, expected);
        end
    endtask

    task automatic stepEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitUntil(input int e);
        checks++;
        if (ecount > e) begin
            errors++;
            $display("[TB] FAIL schedule: at edge %0d, required at most %0d", ecount, e);
        end
        while (ecount < e) stepEdges(1);
    endtask

    // Shift nbits of w MSB first; align_edge > 0 places the FIFO write of the last bit on that edge
    task automatic applyStimulus(input logic [7:0] w, input int nbits, input int align_edge);
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi  = w[i];
            sclk = 1'b0;
            stepEdges(2);
            if (i == 0 && align_edge > 0) waitUntil(align_edge - 4);
            sclk = 1'b1;
            stepEdges(2);
        end
    endtask

    task automatic startFrame();
        cs_n = 1'b0;
        stepEdges(2);
    endtask

    task automatic endFrame();
        stepEdges(2);
        cs_n = 1'b1;
        stepEdges(2);
    endtask

    task automatic pulseClear();
        clr_flags = 1'b1;
        stepEdges(1);
        clr_flags = 1'b0;
        stepEdges(1);
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        sclk      = 1'b0;
        sdi       = 1'b0;
        clr_flags = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("rst_audio", audio, 0);
        checkOutput("rst_stb", sample_stb, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_unf", unf, 0);
        stepEdges(2);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        cs_n   = 1'b1;
        sclk   = 1'b0;
        sdi    = 1'b0;
        clr_flags = 1'b0;
        stepEdges(1);

        // Basic frame of three words, then drain and underflow
        $display("[TB] basic frame and underflow");
        applyReset();
        startFrame();
        exp_q.push_back(8'h7F); applyStimulus(8'h7F, 8, 0);
        exp_q.push_back(8'h80); applyStimulus(8'h80, 8, 0);
        exp_q.push_back(8'h01); applyStimulus(8'h01, 8, 0);
        endFrame();
        waitUntil(120);
        checkOutput("level_three", fifo_level, 3);
        checkOutput("audio_before_pop", audio, 0);
        checkOutput("ovf_clear", ovf, 0);
        waitUntil(300);
        checkOutput("audio_hold", audio, 8'h7F);
        checkOutput("level_two", fifo_level, 2);
        waitUntil(800);
        checkOutput("level_drained", fifo_level, 0);
        checkOutput("unf_before_empty_tick", unf, 0);
        waitUntil(1030);
        checkOutput("unf_set", unf, 1);
        checkOutput("level_after_unf", fifo_level, 0);
`ifdef UNDERFLOW_MUTE_EN
        checkOutput("unf_audio", audio, 0);
`else
        checkOutput("unf_audio", audio, 8'h01);
`endif
        pulseClear();
        checkOutput("unf_cleared", unf, 0);
        checkOutput("ovf_cleared", ovf, 0);

        // Overflow, then push coinciding with a pop while full
        $display("[TB] overflow and full push/pop");
        applyReset();
        startFrame();
        exp_q.push_back(8'h11); applyStimulus(8'h11, 8, 0);
        exp_q.push_back(8'h22); applyStimulus(8'h22, 8, 0);
        exp_q.push_back(8'h33); applyStimulus(8'h33, 8, 0);
        exp_q.push_back(8'h44); applyStimulus(8'h44, 8, 0);
        applyStimulus(8'h55, 8, 0);
        endFrame();
        waitUntil(180);
        checkOutput("level_full", fifo_level, 4);
        checkOutput("ovf_set", ovf, 1);
        pulseClear();
        checkOutput("ovf_cleared2", ovf, 0);
        startFrame();
        exp_q.push_back(8'h66); applyStimulus(8'h66, 8, DIV);
        endFrame();
        waitUntil(260);
        checkOutput("level_full_pushpop", fifo_level, 4);
        checkOutput("ovf_full_pushpop", ovf, 0);
        waitUntil(1290);
        checkOutput("level_drained2", fifo_level, 0);
        checkOutput("unf_none", unf, 0);

        // Push coinciding with a tick while empty
        $display("[TB] empty push/tick");
        waitUntil(1400);
        startFrame();
        exp_q.push_back(8'h5A); applyStimulus(8'h5A, 8, 6 * DIV);
        endFrame();
        waitUntil(1542);
        checkOutput("unf_empty_push", unf, 1);
        checkOutput("level_empty_push", fifo_level, 1);
        waitUntil(1800);
        checkOutput("level_after_5a", fifo_level, 0);

        // Partial word discarded by cs_n
        $display("[TB] partial word discard");
        startFrame();
        applyStimulus(8'hA5, 5, 0);
        cs_n = 1'b1;
        stepEdges(4);
        startFrame();
        exp_q.push_back(8'h3C); applyStimulus(8'h3C, 8, 0);
        endFrame();
        waitUntil(1880);
        checkOutput("level_partial", fifo_level, 1);

        // Reset mid-frame with three buffered words
        $display("[TB] reset mid-frame");
        waitUntil(2060);
        checkOutput("audio_3c", audio, 8'h3C);
        startFrame();
        applyStimulus(8'h12, 8, 0);
        applyStimulus(8'h34, 8, 0);
        applyStimulus(8'h56, 8, 0);
        applyStimulus(8'hFF, 3, 0);
        stepEdges(6);
        checkOutput("level_before_reset", fifo_level, 3);
        applyReset();
        startFrame();
        exp_q.push_back(8'h9C); applyStimulus(8'h9C, 8, 0);
        endFrame();
        waitUntil(270);
        checkOutput("audio_after_reset", audio, 8'h9C);
        checkOutput("level_after_reset", fifo_level, 0);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: time %0t reached, required completion earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
